// File: rtl/keypad_entry_if.sv
// Keypad entry bus: scanner key events in, live/committed BCD entry and status strobes out.
interface keypad_entry_if #(
   parameter int NUM_DIGITS = 4
);
   logic [3:0]              key_code;
   logic                    data_ready;
   logic [4*NUM_DIGITS-1:0] buffer;
   logic [2:0]              digit_count;
   logic [4*NUM_DIGITS-1:0] value;
   logic                    value_valid;
   logic                    entry_error;
   logic                    timeout;

   modport master (
      output key_code, data_ready,
      input  buffer, digit_count, value, value_valid, entry_error, timeout
   );

   modport slave (
      input  key_code, data_ready,
      output buffer, digit_count, value, value_valid, entry_error, timeout
   );
endinterface

// File: rtl/keypad_entry.sv
// Assembles scanner key events into a BCD entry; '*' clears, '#' commits with a one-cycle strobe.
// One-cycle latency from the sampling edge; no backpressure, every key event is consumed.
module keypad_entry #(
   parameter int NUM_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input logic          clock,
   input logic          reset,
   keypad_entry_if.slave kp
);
   localparam int BW = 4 * NUM_DIGITS;
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic {IDLE, ENTRY} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   buf_q, buf_d;
   logic [BW-1:0]   val_q, val_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            dr_q;
   logic            vv_q, vv_d;
   logic            err_q, err_d;
   logic            to_q, to_d;

   logic            key_evt;
   logic            is_digit;
   logic            is_letter;
   logic            key_act;

   assign key_evt   = kp.data_ready & ~dr_q;
   assign is_digit  = (kp.key_code <= 4'd9);
   assign is_letter = (kp.key_code >= 4'hA) && (kp.key_code <= 4'hD);
   // Letters are invisible: they neither act nor disturb the inactivity timer.
   assign key_act   = key_evt & ~is_letter;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         buf_q   <= '0;
         val_q   <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         dr_q    <= 1'b0;
         vv_q    <= 1'b0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         val_q   <= val_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         dr_q    <= kp.data_ready;
         vv_q    <= vv_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      val_d   = val_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      vv_d    = 1'b0;
      err_d   = 1'b0;
      to_d    = 1'b0;

      if (key_act) begin
         if (is_digit) begin
            if (cnt_q < 3'(NUM_DIGITS)) begin
               buf_d   = (buf_q << 4) | BW'(kp.key_code);
               cnt_d   = cnt_q + 3'd1;
               tmr_d   = '0;
               state_d = ENTRY;
            end else begin
               // Rejected digit freezes the timer for this cycle so expiry cannot coincide with the error strobe.
               err_d = 1'b1;
            end
         end else if (kp.key_code == 4'hE) begin
            buf_d   = '0;
            cnt_d   = '0;
            tmr_d   = '0;
            state_d = IDLE;
         end else begin
            if (state_q == ENTRY) begin
               val_d   = buf_q;
               vv_d    = 1'b1;
               buf_d   = '0;
               cnt_d   = '0;
               tmr_d   = '0;
               state_d = IDLE;
            end else begin
               err_d = 1'b1;
            end
         end
      end else if ((state_q == ENTRY) && (TIMEOUT_CYCLES != 0)) begin
         if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
            buf_d   = '0;
            cnt_d   = '0;
            tmr_d   = '0;
            to_d    = 1'b1;
            state_d = IDLE;
         end else begin
            tmr_d = tmr_q + TW'(1);
         end
      end
   end

   assign kp.buffer      = buf_q;
   assign kp.digit_count = cnt_q;
   assign kp.value       = val_q;
   assign kp.value_valid = vv_q;
   assign kp.entry_error = err_q;
   assign kp.timeout     = to_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: commit, overflow, clear, held key, timeout and async reset.
module tb_keypad_entry;
   logic clock;
   logic reset;
   int   checks;
   int   errors;

   keypad_entry_if #(.NUM_DIGITS(4)) kp ();

   keypad_entry #(.NUM_DIGITS(4), .TIMEOUT_CYCLES(20)) dut (
      .clock (clock),
      .reset (reset),
      .kp    (kp)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One key event; returns 1ns after the edge that sampled it.
   task automatic press(input logic [3:0] k);
      @(posedge clock);
      #1;
      kp.key_code   = k;
      kp.data_ready = 1'b1;
      @(posedge clock);
      #1;
      kp.data_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_reset;
      reset         = 1'b0;
      kp.key_code   = 4'h0;
      kp.data_ready = 1'b0;
      idle(3);
      checks++;
      if (kp.buffer !== 16'h0 || kp.digit_count !== 3'd0 || kp.value !== 16'h0) begin
         errors++;
         $display("FAIL reset_data: buffer=%h count=%0d value=%h want 0/0/0", kp.buffer, kp.digit_count, kp.value);
      end
      checks++;
      if ({kp.value_valid, kp.entry_error, kp.timeout} !== 3'b000) begin
         errors++;
         $display("FAIL reset_strobes: got %b want 000", {kp.value_valid, kp.entry_error, kp.timeout});
      end
      #4 reset = 1'b1;
      idle(2);
   endtask

   task automatic test_commit;
      press(4'h1);
      checks++;
      if (kp.buffer !== 16'h0001 || kp.digit_count !== 3'd1) begin
         errors++;
         $display("FAIL commit_d1: buffer=%h count=%0d want 0001/1", kp.buffer, kp.digit_count);
      end
      idle(3);
      press(4'h2);
      checks++;
      if (kp.buffer !== 16'h0012 || kp.digit_count !== 3'd2) begin
         errors++;
         $display("FAIL commit_d2: buffer=%h count=%0d want 0012/2", kp.buffer, kp.digit_count);
      end
      idle(3);
      press(4'h3);
      checks++;
      if (kp.buffer !== 16'h0123 || kp.digit_count !== 3'd3) begin
         errors++;
         $display("FAIL commit_d3: buffer=%h count=%0d want 0123/3", kp.buffer, kp.digit_count);
      end
      idle(3);
      press(4'hF);
      checks++;
      if (kp.value !== 16'h0123 || kp.value_valid !== 1'b1) begin
         errors++;
         $display("FAIL commit_value: value=%h valid=%b want 0123/1", kp.value, kp.value_valid);
      end
      checks++;
      if (kp.buffer !== 16'h0 || kp.digit_count !== 3'd0) begin
         errors++;
         $display("FAIL commit_clear: buffer=%h count=%0d want 0000/0", kp.buffer, kp.digit_count);
      end
      idle(1);
      checks++;
      if (kp.value_valid !== 1'b0 || kp.value !== 16'h0123) begin
         errors++;
         $display("FAIL commit_pulse: valid=%b value=%h want 0/0123", kp.value_valid, kp.value);
      end
      idle(2);
   endtask

   task automatic test_overflow;
      logic [3:0] seq [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
      for (int i = 0; i < 4; i++) begin
         press(seq[i]);
         idle(3);
      end
      press(4'h5);
      checks++;
      if (kp.entry_error !== 1'b1 || kp.buffer !== 16'h1234 || kp.digit_count !== 3'd4) begin
         errors++;
         $display("FAIL overflow_err: err=%b buffer=%h count=%0d want 1/1234/4", kp.entry_error, kp.buffer, kp.digit_count);
      end
      idle(1);
      checks++;
      if (kp.entry_error !== 1'b0) begin
         errors++;
         $display("FAIL overflow_pulse: err=%b want 0", kp.entry_error);
      end
      idle(2);
      press(4'hF);
      checks++;
      if (kp.value !== 16'h1234 || kp.value_valid !== 1'b1) begin
         errors++;
         $display("FAIL overflow_commit: value=%h valid=%b want 1234/1", kp.value, kp.value_valid);
      end
      idle(3);
   endtask

   task automatic test_clear;
      press(4'h7);
      idle(3);
      press(4'h8);
      checks++;
      if (kp.buffer !== 16'h0078) begin
         errors++;
         $display("FAIL clear_pre: buffer=%h want 0078", kp.buffer);
      end
      idle(3);
      press(4'hE);
      checks++;
      if (kp.buffer !== 16'h0 || kp.digit_count !== 3'd0 ||
          {kp.value_valid, kp.entry_error, kp.timeout} !== 3'b000) begin
         errors++;
         $display("FAIL clear_star: buffer=%h count=%0d strobes=%b want 0000/0/000", kp.buffer, kp.digit_count,
                  {kp.value_valid, kp.entry_error, kp.timeout});
      end
      idle(3);
      press(4'hF);
      checks++;
      if (kp.entry_error !== 1'b1 || kp.value_valid !== 1'b0 || kp.value !== 16'h1234) begin
         errors++;
         $display("FAIL clear_hash_idle: err=%b valid=%b value=%h want 1/0/1234", kp.entry_error, kp.value_valid, kp.value);
      end
      idle(1);
      checks++;
      if (kp.entry_error !== 1'b0) begin
         errors++;
         $display("FAIL clear_err_pulse: err=%b want 0", kp.entry_error);
      end
      idle(2);
   endtask

   task automatic test_held_key;
      @(posedge clock);
      #1;
      kp.key_code   = 4'h9;
      kp.data_ready = 1'b1;
      idle(6);
      kp.data_ready = 1'b0;
      checks++;
      if (kp.buffer !== 16'h0009 || kp.digit_count !== 3'd1) begin
         errors++;
         $display("FAIL held_single: buffer=%h count=%0d want 0009/1", kp.buffer, kp.digit_count);
      end
      idle(2);
      press(4'hA);
      checks++;
      if (kp.buffer !== 16'h0009 || kp.digit_count !== 3'd1 ||
          {kp.value_valid, kp.entry_error, kp.timeout} !== 3'b000) begin
         errors++;
         $display("FAIL held_letter: buffer=%h count=%0d strobes=%b want 0009/1/000", kp.buffer, kp.digit_count,
                  {kp.value_valid, kp.entry_error, kp.timeout});
      end
      idle(1);
      press(4'hE);
      idle(3);
   endtask

   task automatic test_timeout;
      press(4'h5);
      for (int k = 1; k < 20; k++) begin
         idle(1);
         checks++;
         if (kp.timeout !== 1'b0 || kp.digit_count !== 3'd1) begin
            errors++;
            $display("FAIL timeout_early: cycle %0d timeout=%b count=%0d want 0/1", k, kp.timeout, kp.digit_count);
         end
      end
      idle(1);
      checks++;
      if (kp.timeout !== 1'b1 || kp.buffer !== 16'h0 || kp.digit_count !== 3'd0 || kp.value !== 16'h1234) begin
         errors++;
         $display("FAIL timeout_fire: timeout=%b buffer=%h count=%0d value=%h want 1/0000/0/1234", kp.timeout,
                  kp.buffer, kp.digit_count, kp.value);
      end
      idle(1);
      checks++;
      if (kp.timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse: timeout=%b want 0", kp.timeout);
      end
      idle(2);
   endtask

   task automatic test_async_reset;
      press(4'h4);
      idle(3);
      press(4'h2);
      #3 reset = 1'b0;
      #1;
      checks++;
      if (kp.buffer !== 16'h0 || kp.digit_count !== 3'd0 || kp.value !== 16'h0 ||
          {kp.value_valid, kp.entry_error, kp.timeout} !== 3'b000) begin
         errors++;
         $display("FAIL async_reset: buffer=%h count=%0d value=%h strobes=%b want all 0", kp.buffer, kp.digit_count,
                  kp.value, {kp.value_valid, kp.entry_error, kp.timeout});
      end
      #12 reset = 1'b1;
      idle(2);
      press(4'h3);
      idle(3);
      press(4'hF);
      checks++;
      if (kp.value !== 16'h0003 || kp.value_valid !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_commit: value=%h valid=%b want 0003/1", kp.value, kp.value_valid);
      end
      idle(2);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_commit();
      test_overflow();
      test_clear();
      test_held_key();
      test_timeout();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
